cache: RTL and testbench

CACHE -- requirements
Module: cache

---
 rtl/cache.sv | 57 +++++
 tb/tb_cache.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cache.sv
// Direct-mapped, one-word-per-line cache with a combinational hit/read path and a shared tri-state data bus.
// Writes land at the rising edge; the same-cycle read path still shows the old contents.
module cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 28,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  we,
  input  logic                  oe,
  output logic                  found
);

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_BITS;

  logic [LINES-1:0]      r_valid;
  logic [TAG_WIDTH-1:0]  r_tag  [LINES];
  logic [DATA_WIDTH-1:0] r_data [LINES];

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_WIDTH-1:0]  w_tag;
  logic                  w_hit;
  logic                  w_drive;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_index = addr[INDEX_BITS-1:0];
  assign w_tag   = addr[ADDR_WIDTH-1:INDEX_BITS];

  // Reset gates the hit so found stays low for the whole reset cycle.
  assign w_hit   = !rst && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign found   = w_hit;

  assign w_drive = oe && !we;
  assign w_rdata = w_hit ? r_data[w_index] : '0;
  assign data    = w_drive ? w_rdata : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (we) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= data;
    end
  end

endmodule

// File: tb/tb_cache.sv
// Randomised bench for cache: an address-keyed reference memory where a write evicts any alias sharing its index.
module tb_cache;

  localparam int DW = 32;
  localparam int AW = 28;
  localparam int IB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          we;
  logic          oe;
  logic          found;
  wire  [DW-1:0] data;
  logic [DW-1:0] tb_dat;
  logic          tb_drv;

  int total = 0;
  int bad   = 0;

  // Reference: address -> word for every address that currently hits.
  logic [DW-1:0] mem [logic [AW-1:0]];

  assign data = tb_drv ? tb_dat : {DW{1'bz}};

  always #5 clk = ~clk;

  cache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INDEX_BITS(IB)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .data  (data),
    .we    (we),
    .oe    (oe),
    .found (found)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (addr=%0h t=%0t)", tag, got, exp, addr, $time);
    end
  endtask

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [AW-1:0] victims[$];
    foreach (mem[k]) begin
      if (k[IB-1:0] == a[IB-1:0] && k != a) victims.push_back(k);
    end
    foreach (victims[i]) mem.delete(victims[i]);
    mem[a] = d;
  endfunction

  function automatic logic exp_found(input logic [AW-1:0] a);
    return mem.exists(a);
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    addr   = a;
    we     = 1'b1;
    oe     = 1'($urandom_range(0, 1));
    tb_dat = d;
    tb_drv = 1'b1;
    #1;
    chk("wr_found_prewrite", {63'd0, found}, {63'd0, exp_found(a)});
    chk("wr_bus_undriven", {32'd0, data}, {32'd0, d});
    @(posedge clk);
    model_write(a, d);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    logic f;
    @(negedge clk);
    addr   = a;
    we     = 1'b0;
    oe     = 1'b1;
    tb_drv = 1'b0;
    #1;
    f = exp_found(a);
    chk("rd_found", {63'd0, found}, {63'd0, f});
    chk("rd_data", {32'd0, data}, f ? {32'd0, mem[a]} : 64'd0);
  endtask

  // With oe=0 the bench drives zeros; any cache drive would corrupt the bus value.
  task automatic do_idle(input logic [AW-1:0] a);
    @(negedge clk);
    addr   = a;
    we     = 1'b0;
    oe     = 1'b0;
    tb_dat = '0;
    tb_drv = 1'b1;
    #1;
    chk("idle_found", {63'd0, found}, {63'd0, exp_found(a)});
    chk("idle_hiz", {32'd0, data}, 64'd0);
  endtask

  task automatic do_reset(input logic with_write, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rst    = 1'b1;
    addr   = a;
    we     = with_write;
    oe     = 1'b0;
    tb_dat = d;
    tb_drv = with_write;
    #1;
    chk("rst_found_low", {63'd0, found}, 64'd0);
    @(posedge clk);
    mem.delete();
    @(negedge clk);
    rst    = 1'b0;
    we     = 1'b0;
    tb_drv = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom);
    return AW'(28'h100 + $urandom_range(0, 47));
  endfunction

  initial begin
    logic [AW-1:0] olds[$];
    rst = 1'b1; we = 1'b0; oe = 1'b0; addr = '0; tb_dat = '0; tb_drv = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Post-reset miss reads zero.
    do_read(28'h11E);
    chk("reset_miss_found", {63'd0, found}, 64'd0);
    chk("reset_miss_data", {32'd0, data}, 64'd0);

    do_write(28'h120, 32'h78000001);
    do_read(28'h120);
    chk("basic_hit_data", {32'd0, data}, 64'h78000001);
    do_idle(28'h120);

    do_write(28'h11C, 32'h78000000);
    do_write(28'h11E, 32'h78000000);
    do_read(28'h11C);
    chk("neighbour_hit", {63'd0, found}, 64'd1);
    do_read(28'h11D);
    chk("neighbour_miss", {63'd0, found}, 64'd0);

    do_write(28'h120, 32'h11111111);
    do_write(28'h130, 32'h22222222);
    do_read(28'h130);
    chk("alias_new_data", {32'd0, data}, 64'h22222222);
    do_read(28'h120);
    chk("alias_evicted", {63'd0, found}, 64'd0);

    do_write(28'h11A, 32'h7800000A);
    do_write(28'h11A, 32'h0000000B);
    do_read(28'h11A);
    chk("overwrite_in_place", {32'd0, data}, 64'h0000000B);

    do_reset(1'b1, 28'h122, 32'hDEADBEEF);
    foreach (olds[i]) olds.delete(i);
    olds = '{28'h122, 28'h11A, 28'h130, 28'h11C, 28'h11E};
    foreach (olds[i]) begin
      do_read(olds[i]);
      chk("post_rst_miss", {63'd0, found}, 64'd0);
    end

    for (int n = 0; n < 600; n++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 45)       do_write(rand_addr(), $urandom);
      else if (op < 88)  do_read(rand_addr());
      else if (op < 96)  do_idle(rand_addr());
      else               do_reset(1'($urandom_range(0, 1)), rand_addr(), $urandom);
    end

    // Sweep every tracked address once more so stale state is caught.
    foreach (mem[k]) olds.push_back(k);
    foreach (olds[i]) do_read(olds[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
